// File: rtl/jtkiwi_shr_port_if.sv
// jtkiwi_shr_port_if: sub-CPU bus and shared-RAM request bundle for jtkiwi_shr_port.
//   master: sub CPU + main-side arbiter/RAM (drives cpu_cs/cpu_rnw/cpu_addr/cpu_dout, shr_grant/shr_dout)
//   slave : jtkiwi_shr_port (drives cpu_din/cpu_wait_n, shr_cs/shr_addr/shr_din/sub_rnw, timeout)
interface jtkiwi_shr_port_if #(parameter int AW = 13);
  logic          cpu_cs;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic [7:0]    cpu_din;
  logic          cpu_wait_n;
  logic          shr_cs;
  logic [AW-1:0] shr_addr;
  logic [7:0]    shr_din;
  logic          sub_rnw;
  logic          shr_grant;
  logic [7:0]    shr_dout;
  logic          timeout;
  modport master (
    output cpu_cs, cpu_rnw, cpu_addr, cpu_dout, shr_grant, shr_dout,
    input  cpu_din, cpu_wait_n, shr_cs, shr_addr, shr_din, sub_rnw, timeout
  );
  modport slave (
    input  cpu_cs, cpu_rnw, cpu_addr, cpu_dout, shr_grant, shr_dout,
    output cpu_din, cpu_wait_n, shr_cs, shr_addr, shr_din, sub_rnw, timeout
  );
endinterface

// File: rtl/jtkiwi_shr_port.sv
// jtkiwi_shr_port: sub-CPU side of the shared comms RAM; latches a sub-CPU cycle into a request and stalls the CPU until served.
//   rst/clk : asynchronous active-high reset, system clock
//   bus     : jtkiwi_shr_port_if.slave (sub-CPU bus, shared-RAM request/grant/data, sticky timeout flag)
//   RD_LAT  : clocks from grant to valid shr_dout; TIMEOUT : REQ clocks before forced completion
//   JTKIWI_SHR_TIMEOUT_EN : when defined, REQ gives up after TIMEOUT clocks without grant
module jtkiwi_shr_port #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input logic rst,
  input logic clk,
  jtkiwi_shr_port_if.slave bus
);
  localparam int CW = $clog2(RD_LAT + 2);
  if (TIMEOUT < 1 || TIMEOUT > 511) $error("TIMEOUT out of range");
  typedef enum logic [1:0] {IDLE, REQ, ACCESS, DONE} state_t;
  state_t st, st_nx;
  logic [CW-1:0] cnt;
  logic tout, fire;
  // wait_n forced high during reset even if the CPU already drives cpu_cs
  assign bus.cpu_wait_n = rst | ~(bus.cpu_cs & (st != DONE));
  // forced completion: still requested, no grant, counter expired
  assign fire = (st == REQ) & bus.cpu_cs & ~bus.shr_grant & tout;
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    st_nx = bus.cpu_cs ? REQ : IDLE;
      REQ:     st_nx = !bus.cpu_cs ? IDLE : bus.shr_grant ? ACCESS : tout ? DONE : REQ;
      ACCESS:  st_nx = !bus.cpu_cs ? IDLE : cnt == '0 ? DONE : ACCESS;
      default: st_nx = bus.cpu_cs ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      cnt          <= '0;
      bus.shr_cs   <= 1'b0;
      bus.shr_addr <= '0;
      bus.shr_din  <= '0;
      bus.sub_rnw  <= 1'b1;
      bus.cpu_din  <= '0;
    end else begin
      st <= st_nx;
      if (st == IDLE && bus.cpu_cs) begin
        bus.shr_addr <= bus.cpu_addr;
        bus.shr_din  <= bus.cpu_dout;
        bus.sub_rnw  <= bus.cpu_rnw;
        bus.shr_cs   <= 1'b1;
      end
      if (st == REQ && bus.shr_grant) cnt <= CW'(RD_LAT);
      if (st == ACCESS && cnt != '0) cnt <= cnt - 1'b1;
      if (st == ACCESS && st_nx == DONE && bus.sub_rnw) bus.cpu_din <= bus.shr_dout;
      if (fire) bus.cpu_din <= 8'hFF;
      // release the RAM as soon as the access ends or is aborted
      if (st != IDLE && (st_nx == DONE || st_nx == IDLE)) bus.shr_cs <= 1'b0;
    end
  end
`ifdef JTKIWI_SHR_TIMEOUT_EN
  logic [8:0] tcnt;
  assign tout = tcnt == 9'(TIMEOUT - 1);
  always_ff @(posedge clk, posedge rst) begin
    if (rst) begin
      tcnt        <= '0;
      bus.timeout <= 1'b0;
    end else begin
      tcnt <= st == REQ ? tcnt + 1'b1 : '0;
      if (fire) bus.timeout <= 1'b1;
    end
  end
`else
  assign tout        = 1'b0;
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_jtkiwi_shr_port.sv
// tb_jtkiwi_shr_port: directed bench for jtkiwi_shr_port with an idle/contending main side and registered RAM model.
module tb_jtkiwi_shr_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  jtkiwi_shr_port_if #(.AW(13)) bus();
  jtkiwi_shr_port #(.RD_LAT(1), .TIMEOUT(16)) dut (.rst(rst), .clk(clk), .bus(bus));
  logic        grant_en = 1'b0;
  logic        pre_we   = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic [7:0]  ram [8192];
  int n_chk = 0;
  int n_err = 0;
  int lows;
  logic cs1, ok;
  assign bus.shr_grant = bus.shr_cs & grant_en;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.shr_cs && bus.shr_grant && !bus.sub_rnw) ram[bus.shr_addr] <= bus.shr_din;
    bus.shr_dout <= ram[bus.shr_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic poke(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask
  task automatic start(input logic [12:0] a, input logic rnw, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_addr = a; bus.cpu_rnw = rnw; bus.cpu_dout = d; bus.cpu_cs = 1'b1;
  endtask
  task automatic release_cs();
    @(negedge clk);
    bus.cpu_cs = 1'b0;
  endtask
  // counts clocks with wait_n low, bounded; cs1 is shr_cs after the first edge
  task automatic run(output int n, output logic c1);
    n = 0;
    c1 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (i == 0) c1 = bus.shr_cs;
      if (bus.cpu_wait_n) break;
      n++;
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    bus.cpu_cs = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = '0; bus.cpu_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wait_n", bus.cpu_wait_n, 1);
    chk("rst_shr_cs", bus.shr_cs, 0);
    chk("rst_shr_addr", bus.shr_addr, 0);
    chk("rst_shr_din", bus.shr_din, 0);
    chk("rst_sub_rnw", bus.sub_rnw, 1);
    chk("rst_cpu_din", bus.cpu_din, 0);
    chk("rst_timeout", bus.timeout, 0);
    @(negedge clk); bus.cpu_cs = 1'b0;
    @(negedge clk); rst = 1'b0;
    poke(13'h0123, 8'h5A);
    poke(13'h1FFE, 8'h11);
    poke(13'h0ABC, 8'h77);
    poke(13'h0055, 8'h33);
    grant_en = 1'b1;
    start(13'h0123, 1'b1, 8'h00);
    run(lows, cs1);
    chk("rd_shr_cs_1clk", cs1, 1);
    chk("rd_wait_clks", lows, 3);
    chk("rd_data", bus.cpu_din, 8'h5A);
    chk("rd_done_shr_cs", bus.shr_cs, 0);
    release_cs();
    start(13'h1FFF, 1'b0, 8'hC3);
    run(lows, cs1);
    chk("wr_wait_clks", lows, 3);
    release_cs();
    @(negedge clk);
    chk("wr_ram", ram[13'h1FFF], 8'hC3);
    chk("wr_neighbour", ram[13'h1FFE], 8'h11);
    grant_en = 1'b0;
    start(13'h0ABC, 1'b1, 8'h00);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.cpu_wait_n || !bus.shr_cs || bus.shr_addr !== 13'h0ABC) ok = 1'b0;
    end
    chk("cont_stall_stable", ok, 1);
    @(negedge clk); grant_en = 1'b1;
    run(lows, cs1);
    chk("cont_clks_after_grant", lows, 2);
    chk("cont_data", bus.cpu_din, 8'h77);
    chk("cont_sub_rnw", bus.sub_rnw, 1);
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.shr_cs || !bus.cpu_wait_n) ok = 1'b0;
    end
    chk("held_single_req", ok, 1);
    release_cs();
    @(negedge clk); bus.cpu_cs = 1'b1;
    run(lows, cs1);
    chk("rearm_shr_cs", cs1, 1);
    chk("rearm_wait_clks", lows, 3);
    release_cs();
    grant_en = 1'b0;
    start(13'h0055, 1'b0, 8'h99);
    repeat (3) @(posedge clk);
    release_cs();
    @(posedge clk); #1;
    chk("abort_shr_cs", bus.shr_cs, 0);
    @(negedge clk);
    chk("abort_ram", ram[13'h0055], 8'h33);
    chk("abort_cpu_din", bus.cpu_din, 8'h77);
    grant_en = 1'b1;
    start(13'h0055, 1'b1, 8'h00);
    run(lows, cs1);
    chk("abort_then_rd_clks", lows, 3);
    chk("abort_then_rd_data", bus.cpu_din, 8'h33);
    release_cs();
    grant_en = 1'b0;
    start(13'h0123, 1'b1, 8'h00);
`ifdef JTKIWI_SHR_TIMEOUT_EN
    run(lows, cs1);
    chk("tout_req_clks", lows, 16);
    chk("tout_data", bus.cpu_din, 8'hFF);
    chk("tout_flag", bus.timeout, 1);
    chk("tout_shr_cs", bus.shr_cs, 0);
`else
    repeat (1000) @(posedge clk);
    #1;
    chk("nogrant_wait_n", bus.cpu_wait_n, 0);
    chk("nogrant_shr_cs", bus.shr_cs, 1);
    chk("nogrant_timeout", bus.timeout, 0);
`endif
    release_cs();
    @(negedge clk);
    grant_en = 1'b1;
    start(13'h0ABC, 1'b0, 8'hEE);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_access_shr_cs", bus.shr_cs, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wait_n", bus.cpu_wait_n, 1);
    chk("rst_mid_shr_cs", bus.shr_cs, 0);
    chk("rst_mid_shr_addr", bus.shr_addr, 0);
    chk("rst_mid_shr_din", bus.shr_din, 0);
    chk("rst_mid_sub_rnw", bus.sub_rnw, 1);
    chk("rst_mid_cpu_din", bus.cpu_din, 0);
    chk("rst_mid_timeout", bus.timeout, 0);
    release_cs();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
